// File: rtl/nand_sweep_checker_pkg.sv
// Shared definitions for the NAND sweep checker: FSM states, vector mapping
// and the expected NAND response table.
package nand_sweep_checker_pkg;

  localparam int unsigned VEC_W   = 2;
  localparam int unsigned NUM_VEC = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_SAMPLE = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Expected y for vec_idx 0..3 ({a,b} = 00, 01, 10, 11).
  localparam logic [NUM_VEC-1:0] EXP_Y = 4'b0111;

  // Vector index maps directly onto {a,b}.
  function automatic logic [1:0] vec_to_ab(input logic [VEC_W-1:0] idx);
    return idx;
  endfunction

endpackage

// File: rtl/nand_sweep_checker_settle_counter.sv
// Loadable down-counter timing the settle window after each new vector.
module settle_counter #(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic load,
  input  logic dec,
  output logic expired
);

  localparam int unsigned CNT_W = $clog2(SETTLE_CYCLES + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= CNT_W'(SETTLE_CYCLES);
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  // Last settle cycle: the next edge moves on to sampling.
  assign expired = (cnt == CNT_W'(1));

endmodule

// File: rtl/nand_sweep_checker.sv
// Drives all four NAND input vectors for RUNS sweeps, samples the gate output
// after a settle window and reports mismatch count, per-vector flags and verdict.
module nand_sweep_checker
  import nand_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned RUNS          = 1,
  parameter int unsigned ERR_W         = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  output logic                 gate_a,
  output logic                 gate_b,
  input  logic                 gate_y,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [ERR_W-1:0]     err_count,
  output logic [NUM_VEC-1:0]   fail_vec,
  output logic [VEC_W-1:0]     vec_idx
);

  localparam int unsigned   RUN_W    = (RUNS > 1) ? $clog2(RUNS) : 1;
  localparam logic [RUN_W-1:0] LAST_RUN = RUN_W'(RUNS - 1);

  state_e             state;
  state_e             state_nxt;
  logic [RUN_W-1:0]   sweep;
  logic               settle_expired;
  logic               last_vec_c;
  logic               mismatch_c;
  logic [VEC_W-1:0]   vec_nxt_c;

  logic accept;
  logic load_settle;
  logic dec_settle;
  logic do_sample;
  logic advance;
  logic finish;

  settle_counter #(
    .SETTLE_CYCLES(SETTLE_CYCLES)
  ) u_settle (
    .clk     (clk),
    .rst_n   (rst_n),
    .load    (load_settle),
    .dec     (dec_settle),
    .expired (settle_expired)
  );

  assign last_vec_c = (vec_idx == VEC_W'(NUM_VEC - 1)) && (sweep == LAST_RUN);
  assign vec_nxt_c  = vec_idx + VEC_W'(1);
  assign mismatch_c = do_sample && (gate_y != EXP_Y[vec_idx]);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_SETTLE;
      ST_SETTLE: if (settle_expired) state_nxt = ST_SAMPLE;
      ST_SAMPLE: state_nxt = last_vec_c ? ST_DONE : ST_SETTLE;
      ST_DONE:   state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    accept      = 1'b0;
    load_settle = 1'b0;
    dec_settle  = 1'b0;
    do_sample   = 1'b0;
    advance     = 1'b0;
    finish      = 1'b0;
    case (state)
      ST_IDLE: begin
        accept      = start;
        load_settle = start;
      end
      ST_SETTLE: dec_settle = 1'b1;
      ST_SAMPLE: begin
        do_sample = 1'b1;
        if (last_vec_c) begin
          finish = 1'b1;
        end else begin
          advance     = 1'b1;
          load_settle = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Result and vector registers; the verdict folds in the final sample's outcome.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_vec  <= '0;
      vec_idx   <= '0;
      sweep     <= '0;
    end else begin
      done <= finish;
      if (accept) begin
        busy             <= 1'b1;
        pass             <= 1'b0;
        err_count        <= '0;
        fail_vec         <= '0;
        vec_idx          <= '0;
        {gate_a, gate_b} <= vec_to_ab(VEC_W'(0));
        sweep            <= '0;
      end
      if (state == ST_DONE) begin
        busy <= 1'b0;
      end
      if (mismatch_c) begin
        if (err_count != {ERR_W{1'b1}}) begin
          err_count <= err_count + ERR_W'(1);
        end
        fail_vec[vec_idx] <= 1'b1;
      end
      if (finish) begin
        pass <= (fail_vec == '0) && !mismatch_c;
      end
      if (advance) begin
        vec_idx          <= vec_nxt_c;
        {gate_a, gate_b} <= vec_to_ab(vec_nxt_c);
        if (vec_idx == VEC_W'(NUM_VEC - 1)) begin
          sweep <= sweep + RUN_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_nand_sweep_checker.sv
// Scoreboard bench: three checker instances (RUNS = 1, 5, 6) each drive a
// bench-controlled truth-table gate; expected results come from a sweep model.
module tb_nand_sweep_checker;

  localparam int NI     = 3;
  localparam int SETTLE = 2;

  typedef struct packed {
    int         start_cyc;
    int         done_cyc;
    logic [3:0] err;
    logic [3:0] fv;
    logic       pass;
  } exp_t;

  logic       clk;
  logic       rst_n [NI];
  logic       start [NI];
  logic       ga    [NI];
  logic       gb    [NI];
  logic       gy    [NI];
  logic       busy  [NI];
  logic       done  [NI];
  logic       pass  [NI];
  logic [3:0] errc  [NI];
  logic [3:0] fv    [NI];
  logic [1:0] vi    [NI];
  logic [3:0] tt    [NI];
  logic       rst_q [NI];

  exp_t exp_q [NI][$];
  exp_t mon_e;
  logic held_pass [NI];
  bit   held_ok   [NI];
  bit   running;
  int   cyc;
  int   n_cmp;
  int   n_bad;

  function automatic int runs_of(input int g);
    return (g == 0) ? 1 : ((g == 1) ? 5 : 6);
  endfunction

  for (genvar g = 0; g < NI; g++) begin : g_dut
    assign gy[g] = tt[g][{ga[g], gb[g]}];
    nand_sweep_checker #(
      .SETTLE_CYCLES(SETTLE),
      .RUNS         ((g == 0) ? 1 : ((g == 1) ? 5 : 6)),
      .ERR_W        (4)
    ) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .start     (start[g]),
      .gate_a    (ga[g]),
      .gate_b    (gb[g]),
      .gate_y    (gy[g]),
      .busy      (busy[g]),
      .done      (done[g]),
      .pass      (pass[g]),
      .err_count (errc[g]),
      .fail_vec  (fv[g]),
      .vec_idx   (vi[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    for (int g = 0; g < NI; g++) rst_q[g] <= rst_n[g];
  end

  // Reference: a run is RUNS sweeps of the gate's truth table against NAND.
  function automatic exp_t model(input int g, input logic [3:0] t, input int k);
    exp_t e;
    int   bad;
    int   total;
    bad  = 0;
    e.fv = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (t[i] != ((i == 3) ? 1'b0 : 1'b1)) begin
        bad++;
        e.fv[i] = 1'b1;
      end
    end
    total       = bad * runs_of(g);
    e.err       = (total > 15) ? 4'd15 : 4'(total);
    e.pass      = (total == 0);
    e.start_cyc = k + 1;
    e.done_cyc  = k + runs_of(g) * 4 * (SETTLE + 1) + 1;
    return e;
  endfunction

  function automatic void chk(input string name, input int g,
                              input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s inst%0d cyc %0d: got %0d expected %0d", name, g, cyc, act, exp);
    end
  endfunction

  always @(negedge clk) begin
    for (int g = 0; g < NI; g++) begin
      if (!rst_q[g]) begin
        chk("reset_values", g,
            32'({ga[g], gb[g], busy[g], done[g], pass[g], errc[g], fv[g], vi[g]}), 32'd0);
        exp_q[g].delete();
        held_pass[g] = 1'b0;
        held_ok[g]   = 1'b1;
      end else if (done[g]) begin
        if (exp_q[g].size() == 0) begin
          chk("unexpected_done", g, 32'(done[g]), 32'd0);
        end else begin
          mon_e = exp_q[g].pop_front();
          chk("done_cycle", g, 32'(cyc), 32'(mon_e.done_cyc));
          chk("err_count", g, 32'(errc[g]), 32'(mon_e.err));
          chk("fail_vec", g, 32'(fv[g]), 32'(mon_e.fv));
          chk("pass", g, 32'(pass[g]), 32'(mon_e.pass));
          chk("final_ab", g, 32'({ga[g], gb[g]}), 32'd3);
          chk("busy_at_done", g, 32'(busy[g]), 32'd1);
          held_pass[g] = mon_e.pass;
          held_ok[g]   = 1'b1;
        end
      end else begin
        running = 1'b0;
        if (exp_q[g].size() != 0) begin
          mon_e   = exp_q[g][0];
          running = (cyc >= mon_e.start_cyc);
          if (running && cyc > mon_e.done_cyc) begin
            chk("done_missing", g, 32'(done[g]), 32'd1);
            void'(exp_q[g].pop_front());
            running = 1'b0;
          end
        end
        chk("busy", g, 32'(busy[g]), 32'(running));
        if (running) chk("pass_cleared", g, 32'(pass[g]), 32'd0);
        else if (held_ok[g]) chk("pass_held", g, 32'(pass[g]), 32'(held_pass[g]));
      end
    end
  end

  task automatic at_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic wait_idle(input int g);
    int guard;
    guard = 0;
    while (exp_q[g].size() != 0) begin
      @(negedge clk);
      guard++;
      if (guard > 5000) begin
        $display("FAIL wait_idle inst%0d: run never completed", g);
        $fatal(1, "timeout");
      end
    end
    @(negedge clk);
  endtask

  task automatic launch(input int g, input logic [3:0] t, output int sc, output int dc);
    exp_t e;
    wait_idle(g);
    tt[g]    = t;
    start[g] = 1'b1;
    e        = model(g, t, cyc);
    exp_q[g].push_back(e);
    sc = e.start_cyc;
    dc = e.done_cyc;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic poke(input int g, input int c);
    at_cyc(c);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  initial begin
    int   sc, dc, g;
    exp_t e1, e2;
    for (int i = 0; i < NI; i++) begin
      rst_n[i] = 1'b0;
      start[i] = 1'b0;
      tt[i]    = 4'b0111;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) rst_n[i] = 1'b1;

    // Directed: good NAND, stuck-at-1, AND gate, stuck-at-0 with and without saturation.
    launch(0, 4'b0111, sc, dc);
    launch(0, 4'b1111, sc, dc);
    launch(0, 4'b1000, sc, dc);
    launch(1, 4'b0000, sc, dc);
    launch(2, 4'b0000, sc, dc);
    wait_idle(1);
    wait_idle(2);

    // Reset in cycle 6 of a run, then a clean run.
    launch(0, 4'b0111, sc, dc);
    at_cyc(sc + 5);
    rst_n[0] = 1'b0;
    @(negedge clk);
    rst_n[0] = 1'b1;
    launch(0, 4'b0111, sc, dc);

    // Start pulses during SETTLE and during DONE are ignored.
    launch(0, 4'b0111, sc, dc);
    poke(0, sc);
    poke(0, dc);

    // Start held high: two back-to-back runs.
    wait_idle(0);
    tt[0]    = 4'b0110;
    start[0] = 1'b1;
    e1 = model(0, 4'b0110, cyc);
    e2 = model(0, 4'b0110, e1.done_cyc + 1);
    exp_q[0].push_back(e1);
    exp_q[0].push_back(e2);
    at_cyc(e2.start_cyc);
    start[0] = 1'b0;

    // Random truth tables with random stray start pulses.
    for (int n = 0; n < 24; n++) begin
      g = (n % 6 == 5) ? int'($urandom_range(2, 1)) : 0;
      launch(g, 4'($urandom), sc, dc);
      if ($urandom_range(1, 0) == 1) poke(g, sc + int'($urandom_range(dc - sc, 0)));
    end

    for (int i = 0; i < NI; i++) wait_idle(i);
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
